contador_garrafas: RTL and testbench

Upstream stage of the dozen counter. It converts the raw bottle-presence sensor on the conveyor into clean, counted bottle events, and counts accepted bottles modulo DOZEN_SIZE. It emits a one-cycle DOZEN pulse that drives the dozen counter's ENABLE input. Bottles flagged by quality control are counted as rejects. When downstream signals HALT, the dozen-complete pulse is held back.

---
 rtl/contador_garrafas_if.sv | 23 ++
 rtl/contador_garrafas.sv | 112 +++++++++++
 tb/tb_contador_garrafas.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/contador_garrafas_if.sv
// Conveyor-side signal bundle for contador_garrafas.
// The master drives sensor/quality/halt inputs; the slave returns count and status.
interface contador_garrafas_if;
    logic       sensor;
    logic       reject;
    logic       halt;
    logic [3:0] count;
    logic       bottle;
    logic       dozen;
    logic       ready;
    logic       overrun;
    logic [7:0] total_reject;

    modport master (
        output sensor, reject, halt,
        input  count, bottle, dozen, ready, overrun, total_reject
    );

    modport slave (
        input  sensor, reject, halt,
        output count, bottle, dozen, ready, overrun, total_reject
    );
endinterface

// File: rtl/contador_garrafas.sv
// Bottle sensor conditioning and modulo-dozen counter feeding the dozen counter.
// A dozen that completes while downstream is halted is held in PENDING until halt drops.
module contador_garrafas #(
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned DOZEN_SIZE = 12
) (
    input  logic                clock,
    input  logic                reset,
    contador_garrafas_if.slave  bus
);

    localparam logic [3:0] DB_LAST  = 4'(DEBOUNCE - 1);
    localparam logic [3:0] CNT_LAST = 4'(DOZEN_SIZE - 1);

    typedef enum logic {RUN, PENDING} state_t;

    logic       s1, s2, filt, filt_q;
    logic [3:0] dcnt;
    logic       ev, good, rej;

    state_t     state;
    logic [3:0] count;
    logic       bottle, dozen, ready, overrun;
    logic [7:0] total_reject;

    // Synchronizer and debounce: filt flips only after DEBOUNCE consecutive differing samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            filt   <= 1'b0;
            filt_q <= 1'b0;
            dcnt   <= '0;
        end else begin
            s1     <= bus.sensor;
            s2     <= s1;
            filt_q <= filt;
            if (s2 != filt) begin
                if (dcnt == DB_LAST) begin
                    filt <= s2;
                    dcnt <= '0;
                end else begin
                    dcnt <= dcnt + 4'd1;
                end
            end else begin
                dcnt <= '0;
            end
        end
    end

    assign ev   = filt & ~filt_q;
    assign good = ev & ~bus.reject;
    assign rej  = ev & bus.reject;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            count        <= '0;
            bottle       <= 1'b0;
            dozen        <= 1'b0;
            ready        <= 1'b1;
            overrun      <= 1'b0;
            total_reject <= '0;
        end else begin
            bottle <= 1'b0;
            dozen  <= 1'b0;
            if (rej && total_reject != 8'hFF)
                total_reject <= total_reject + 8'd1;
            case (state)
                RUN: begin
                    if (good) begin
                        bottle <= 1'b1;
                        if (count != CNT_LAST) begin
                            count <= count + 4'd1;
                        end else if (!bus.halt) begin
                            count <= '0;
                            dozen <= 1'b1;
                        end else begin
                            state <= PENDING;
                            ready <= 1'b0;
                        end
                    end
                end
                PENDING: begin
                    // Releasing the held dozen and accepting a same-cycle bottle happen together.
                    if (!bus.halt) begin
                        dozen <= 1'b1;
                        state <= RUN;
                        ready <= 1'b1;
                        if (good) begin
                            bottle <= 1'b1;
                            count  <= 4'd1;
                        end else begin
                            count  <= '0;
                        end
                    end else if (good) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.count        = count;
    assign bus.bottle       = bottle;
    assign bus.dozen        = dozen;
    assign bus.ready        = ready;
    assign bus.overrun      = overrun;
    assign bus.total_reject = total_reject;

endmodule

// File: tb/tb_contador_garrafas.sv
// Self-checking bench for contador_garrafas: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the bottle counter.
module tb_contador_garrafas;

    localparam int unsigned DEB = 4;
    localparam int unsigned DS  = 12;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    contador_garrafas_if bus ();

    contador_garrafas #(.DEBOUNCE(DEB), .DOZEN_SIZE(DS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    int nb = 0, nd = 0, nco = 0;

    // Behavioural model: the filtered level flips once the last DEB synchronized samples
    // all disagree with it; a rise of the filtered level is a bottle event one cycle later.
    logic       md1, md2, mfilt, mev, syncv, alldiff, mgood;
    logic       mwin [DEB];
    logic       mpend;
    int         mcount, mrej;
    logic       mbottle, mdozen, moverrun;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            md1 = 1'b0; md2 = 1'b0; mfilt = 1'b0; mev = 1'b0;
            for (int unsigned i = 0; i < DEB; i++) mwin[i] = 1'b0;
            mpend = 1'b0; mcount = 0; mrej = 0;
            mbottle = 1'b0; mdozen = 1'b0; moverrun = 1'b0;
        end else begin
            mbottle = 1'b0;
            mdozen  = 1'b0;
            if (mev && bus.reject && mrej < 255) mrej = mrej + 1;
            mgood = mev && !bus.reject;
            if (!mpend) begin
                if (mgood) begin
                    mbottle = 1'b1;
                    if (mcount < DS - 1) mcount = mcount + 1;
                    else if (!bus.halt) begin mcount = 0; mdozen = 1'b1; end
                    else mpend = 1'b1;
                end
            end else if (!bus.halt) begin
                mdozen = 1'b1;
                mpend  = 1'b0;
                mcount = mgood ? 1 : 0;
                mbottle = mgood;
            end else if (mgood) begin
                moverrun = 1'b1;
            end
            syncv = md2;
            md2   = md1;
            md1   = bus.sensor;
            for (int unsigned i = DEB - 1; i > 0; i--) mwin[i] = mwin[i-1];
            mwin[0] = syncv;
            alldiff = 1'b1;
            for (int unsigned i = 0; i < DEB; i++) if (mwin[i] == mfilt) alldiff = 1'b0;
            mev = alldiff && !mfilt;
            if (alldiff) mfilt = ~mfilt;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            chk("count",        32'(bus.count),        32'(mcount));
            chk("bottle",       32'(bus.bottle),       32'(mbottle));
            chk("dozen",        32'(bus.dozen),        32'(mdozen));
            chk("ready",        32'(bus.ready),        32'(!mpend));
            chk("overrun",      32'(bus.overrun),      32'(moverrun));
            chk("total_reject", 32'(bus.total_reject), 32'(mrej));
            if (bus.bottle === 1'b1) nb++;
            if (bus.dozen === 1'b1) nd++;
            if (bus.bottle === 1'b1 && bus.dozen === 1'b1) nco++;
        end
    end

    task automatic apply_reset();
        @(negedge clock); #1 reset = 1'b1;
        @(negedge clock);
        @(negedge clock); #1 reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic one_bottle(input logic r);
        bus.sensor = 1'b1;
        bus.reject = r;
        repeat (DEB + 4) @(negedge clock);
        bus.sensor = 1'b0;
        repeat (DEB + 4) @(negedge clock);
        bus.reject = 1'b0;
    endtask

    int nb0, nd0;

    initial begin
        bus.sensor = 1'b0;
        bus.reject = 1'b0;
        bus.halt   = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1 chk_on = 1'b1;
        @(negedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_count", 32'(bus.count), 0);
        chk("reset_ready", 32'(bus.ready), 1);

        // Latency of first bottle: output changes at the (DEB+2)th edge after first sample.
        bus.sensor = 1'b1;
        @(posedge clock);
        repeat (DEB + 1) @(posedge clock);
        #1 chk("lat_early_bottle", 32'(bus.bottle), 0);
        @(posedge clock);
        #1 chk("lat_bottle", 32'(bus.bottle), 1);
        chk("lat_count", 32'(bus.count), 1);
        @(negedge clock) bus.sensor = 1'b0;
        repeat (DEB + 4) @(negedge clock);

        // Chattering sensor never qualifies.
        apply_reset();
        nb0 = nb;
        for (int i = 0; i < 20; i++) begin
            bus.sensor = ~bus.sensor;
            @(negedge clock);
        end
        bus.sensor = 1'b0;
        repeat (DEB + 4) @(negedge clock);
        chk("bounce_bottles", 32'(nb - nb0), 0);
        chk("bounce_count", 32'(bus.count), 0);

        // Full dozen, no halt.
        apply_reset();
        nb0 = nb; nd0 = nd;
        for (int i = 0; i < 12; i++) one_bottle(1'b0);
        chk("dozen_bottles", 32'(nb - nb0), 12);
        chk("dozen_pulses", 32'(nd - nd0), 1);
        chk("dozen_coincident", 32'(nco), 1);
        chk("dozen_count", 32'(bus.count), 0);

        // Dozen held by halt, overrun, then release.
        apply_reset();
        for (int i = 0; i < 11; i++) one_bottle(1'b0);
        nd0 = nd;
        bus.halt = 1'b1;
        one_bottle(1'b0);
        chk("halt_count", 32'(bus.count), 11);
        chk("halt_ready", 32'(bus.ready), 0);
        chk("halt_nodozen", 32'(nd - nd0), 0);
        one_bottle(1'b0);
        chk("ovr_flag", 32'(bus.overrun), 1);
        chk("ovr_count", 32'(bus.count), 11);
        bus.halt = 1'b0;
        @(posedge clock);
        #1 chk("release_dozen", 32'(bus.dozen), 1);
        chk("release_count", 32'(bus.count), 0);
        chk("release_ready", 32'(bus.ready), 1);
        @(negedge clock);

        // Reject saturation.
        apply_reset();
        nb0 = nb; nd0 = nd;
        for (int i = 0; i < 300; i++) one_bottle(1'b1);
        chk("rej_sat", 32'(bus.total_reject), 255);
        chk("rej_count", 32'(bus.count), 0);
        chk("rej_nobottle", 32'(nb - nb0), 0);
        chk("rej_nodozen", 32'(nd - nd0), 0);

        // Reset mid-debounce.
        apply_reset();
        for (int i = 0; i < 5; i++) one_bottle(1'b0);
        chk("pre_rst_count", 32'(bus.count), 5);
        bus.sensor = 1'b1;
        repeat (3) @(negedge clock);
        #1 reset = 1'b1;
        #1 chk("rst_count", 32'(bus.count), 0);
        chk("rst_bottle", 32'(bus.bottle), 0);
        chk("rst_dozen", 32'(bus.dozen), 0);
        chk("rst_ready", 32'(bus.ready), 1);
        chk("rst_overrun", 32'(bus.overrun), 0);
        chk("rst_reject", 32'(bus.total_reject), 0);
        @(negedge clock); #1 reset = 1'b0;
        nb0 = nb;
        repeat (DEB + 1) @(posedge clock);
        #1 chk("post_rst_nobottle", 32'(nb - nb0), 0);
        chk("post_rst_count", 32'(bus.count), 0);
        @(negedge clock) bus.sensor = 1'b0;
        repeat (DEB + 6) @(negedge clock);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.sensor = 1'($urandom_range(0, 1));
            bus.reject = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) bus.halt = ~bus.halt;
            if ($urandom_range(0, 59) == 0) begin
                #1 reset = 1'b1;
                @(negedge clock); #1 reset = 1'b0;
            end
            repeat ($urandom_range(1, 12)) @(negedge clock);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
